store_narrow_serializer: RTL and testbench
==========================================

Name: store_narrow_serializer

Overview:
- Store-side counterpart of the load-side sign-extending mux: takes a 32-bit register value plus a width select and writes it to memory as 1, 2 or 4 bytes, little-endian, over an 8-bit write bus.
- Sits between execute/writeback and the byte-wide data memory port.
- Flags values that do not survive the narrowing, meaning the sign-extended narrow value differs from the source.
- Registered FSM with a valid/ready request handshake and a per-byte memory handshake.

Parameters:
ADDR_WIDTH, 32, width of request and memory byte addresses.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  store request valid.
in_ready  output  1  block can accept a request.
select  input  2  width: 00=word, 01=half, 10=word, 11=byte (same encoding as the load mux).
addr  input  ADDR_WIDTH  base byte address.
data  input  32  register value to store.
mem_we  output  1  byte write strobe.
mem_addr  output  ADDR_WIDTH  byte address of the current write.
mem_wdata  output  8  byte being written.
mem_ready  input  1  memory accepts the current byte this cycle.
done  output  1  one-cycle pulse: store complete.
trunc  output  1  valid with done: value not representable at the selected width.

Behaviour:
- Reset (async, immediate): state=IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, trunc=0, byte counter=0. A reset during WRITE aborts the store; no further strobes; no done.
- States: IDLE, WRITE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch addr, data and byte count N (00/10→4, 01→2, 11→1), and compute trunc_l.
  - trunc_l=1 if half and data[31:16] != {16{data[15]}}, or if byte and data[31:8] != {24{data[7]}}; word → 0.
  - Next state WRITE.
- WRITE:
  - in_ready=0, mem_we=1.
  - mem_addr = base+k, modulo 2^ADDR_WIDTH; wraps past all-ones.
  - mem_wdata = data_l[8k+7:8k], with k the byte counter starting at 0.
  - Byte k retires on a cycle with mem_ready=1. Then k increments and the outputs update next cycle.
  - mem_we stays high and outputs hold stable while mem_ready=0; no limit on stall length.
  - On retirement of byte N-1, go to DONE and drop mem_we.
- DONE:
  - done=1 and trunc=trunc_l for exactly one cycle, mem_we=0, in_ready=0.
  - Then go to IDLE; trunc returns to 0.
- Latency with mem_ready tied high: accept at cycle 0, strobes in cycles 1..N, done in cycle N+1, next accept possible in cycle N+2.
- Requests presented while in_ready=0 are ignored and not queued. Upstream holds in_valid.
- mem_wdata and mem_addr must not glitch between bytes. All outputs are registered.
- trunc is informational only: the low N bytes are always written regardless.

Decomposition:
- Shared package holds:
  - width-select constants SEL_WORD0=2'b00, SEL_HALF=2'b01, SEL_WORD1=2'b10, SEL_BYTE=2'b11, also used by the load mux;
  - state encoding IDLE/WRITE/DONE;
  - a function mapping select to byte count.
- One natural sub-module, narrow_fit_check: combinational, (select, data) → trunc, reusable by the ALU for overflow checks.
- Everything else stays in one module.

Test Plan:
- Byte store, select=11, addr=0x100, data=0xFFFFFF80, mem_ready=1:
  - one strobe at 0x100 with wdata 0x80;
  - done in cycle 2, trunc=0.
- Half store with stalls, select=01, addr=0x200, data=0x00001234, mem_ready low for 3 cycles on byte 0:
  - 0x34@0x200 held stable through the stall, then 0x12@0x201;
  - done, trunc=0.
- Word store with address wrap, select=10, addr=0xFFFFFFFE, data=0xDEADBEEF:
  - 0xEF@0xFFFFFFFE, 0xBE@0xFFFFFFFF, 0xAD@0x00000000, 0xDE@0x00000001;
  - trunc=0.
- Truncation:
  - select=01, data=0x00018000 → bytes 0x00, 0x80 written, trunc=1 with done;
  - select=11, data=0x0000007F → trunc=0.
- Reset mid-store: assert reset after byte 1 of a word store → mem_we drops the same cycle; no done; in_ready=1 after release; a new byte store completes normally.
- Back-pressure: hold in_valid continuously with two queued requests → second is accepted only in the cycle after done; no strobes overlap.

Source files
------------

// File: rtl/store_narrow_serializer_pkg.sv
// Shared definitions for the store-side narrowing path.
// Holds the width-select encoding (shared with the load-side mux), the
// serializer state encoding, and small helpers for byte counting and
// byte extraction.
package store_narrow_serializer_pkg;

  // Width-select encoding, identical to the load mux
  localparam logic [1:0] SEL_WORD0 = 2'b00;
  localparam logic [1:0] SEL_HALF  = 2'b01;
  localparam logic [1:0] SEL_WORD1 = 2'b10;
  localparam logic [1:0] SEL_BYTE  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WRITE = 2'b01,
    DONE  = 2'b10
  } state_t;

  // Number of bytes written for a given width select (1, 2 or 4)
  function automatic logic [2:0] sel_to_count(input logic [1:0] sel);
    logic [2:0] cnt;
    case (sel)
      SEL_HALF:  cnt = 3'd2;
      SEL_BYTE:  cnt = 3'd1;
      SEL_WORD0: cnt = 3'd4;
      SEL_WORD1: cnt = 3'd4;
      default:   cnt = 3'd4;
    endcase
    return cnt;
  endfunction

  // Little-endian byte lane idx of a 32-bit word
  function automatic logic [7:0] byte_at(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/store_narrow_serializer_if.sv
// Request and byte-memory bus of the store narrowing serializer.
//   in_valid/in_ready : request handshake
//   select/addr/data  : width select, base byte address, register value
//   mem_we/mem_addr/mem_wdata/mem_ready : per-byte memory write handshake
//   done/trunc        : completion pulse and truncation flag
// master: request/memory-side agent; slave: the serializer.
interface store_narrow_serializer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            select;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           data;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;
  logic                  mem_ready;
  logic                  done;
  logic                  trunc;

  modport master (
    output in_valid, select, addr, data, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata, done, trunc
  );

  modport slave (
    input  in_valid, select, addr, data, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata, done, trunc
  );
endinterface

// File: rtl/store_narrow_serializer_fit.sv
// narrow_fit_check: combinational check of whether a 32-bit value survives
// narrowing to the selected width and sign-extending back.
//   select : width select (word/half/byte)
//   data   : source value
//   trunc  : 1 when the narrowed value differs from the source
module narrow_fit_check
  import store_narrow_serializer_pkg::*;
(
  input  logic [1:0]  select,
  input  logic [31:0] data,
  output logic        trunc
);

  // Compare the bits dropped by narrowing against the narrow sign bit
  always_comb begin
    trunc = 1'b0;
    case (select)
      SEL_HALF:  trunc = (data[31:16] != {16{data[15]}});
      SEL_BYTE:  trunc = (data[31:8]  != {24{data[7]}});
      SEL_WORD0: trunc = 1'b0;
      SEL_WORD1: trunc = 1'b0;
      default:   trunc = 1'b0;
    endcase
  end

endmodule

// File: rtl/store_narrow_serializer.sv
// store_narrow_serializer: writes a 32-bit register value to a byte-wide
// memory port as 1, 2 or 4 little-endian bytes and flags values that do
// not fit the selected width.
//   clock : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of store_narrow_serializer_if (request handshake,
//           per-byte memory handshake, done/trunc result)
// All outputs come straight from registers.
module store_narrow_serializer
  import store_narrow_serializer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input logic                      clock,
  input logic                      reset,
  store_narrow_serializer_if.slave bus
);

  state_t                state_r, state_s;
  logic [1:0]            k_r, k_s;          // index of byte on the bus
  logic [1:0]            last_r, last_s;    // index of the final byte (N-1)
  logic [31:0]           data_r, data_s;
  logic                  trunc_l_r, trunc_l_s;
  logic                  in_ready_r, in_ready_s;
  logic                  mem_we_r, mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_s;
  logic [7:0]            mem_wdata_r, mem_wdata_s;
  logic                  done_r, done_s;
  logic                  trunc_r, trunc_s;
  logic                  fit_trunc_s;

  narrow_fit_check u_fit (
    .select (bus.select),
    .data   (bus.data),
    .trunc  (fit_trunc_s)
  );

  // Next-state and next-output logic; outputs are computed one cycle
  // ahead so the registered bus never glitches between bytes
  always_comb begin
    state_s     = state_r;
    k_s         = k_r;
    last_s      = last_r;
    data_s      = data_r;
    trunc_l_s   = trunc_l_r;
    in_ready_s  = in_ready_r;
    mem_we_s    = mem_we_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    done_s      = 1'b0;
    trunc_s     = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        mem_we_s   = 1'b0;
        if (bus.in_valid && in_ready_r) begin
          state_s     = WRITE;
          k_s         = 2'd0;
          last_s      = 2'(sel_to_count(bus.select) - 3'd1);
          data_s      = bus.data;
          trunc_l_s   = fit_trunc_s;
          in_ready_s  = 1'b0;
          mem_we_s    = 1'b1;
          mem_addr_s  = bus.addr;
          mem_wdata_s = bus.data[7:0];
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        in_ready_s = 1'b0;
        mem_we_s   = 1'b1;
        if (bus.mem_ready && (k_r == last_r)) begin
          // Final byte retires: leave the address/data lines parked
          state_s  = DONE;
          k_s      = 2'd0;
          mem_we_s = 1'b0;
          done_s   = 1'b1;
          trunc_s  = trunc_l_r;
        end else if (bus.mem_ready) begin
          k_s         = k_r + 2'd1;
          mem_addr_s  = mem_addr_r + ADDR_WIDTH'(1);
          mem_wdata_s = byte_at(data_r, k_r + 2'd1);
        end else begin
          state_s = WRITE;
        end
      end
      DONE: begin
        state_s    = IDLE;
        in_ready_s = 1'b1;
        mem_we_s   = 1'b0;
      end
      default: begin
        state_s    = IDLE;
        k_s        = 2'd0;
        in_ready_s = 1'b1;
        mem_we_s   = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      k_r         <= 2'd0;
      last_r      <= 2'd0;
      data_r      <= 32'd0;
      trunc_l_r   <= 1'b0;
      in_ready_r  <= 1'b1;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= 8'd0;
      done_r      <= 1'b0;
      trunc_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      k_r         <= k_s;
      last_r      <= last_s;
      data_r      <= data_s;
      trunc_l_r   <= trunc_l_s;
      in_ready_r  <= in_ready_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      done_r      <= done_s;
      trunc_r     <= trunc_s;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.done      = done_r;
  assign bus.trunc     = trunc_r;

endmodule

// File: tb/tb_store_narrow_serializer.sv
// Self-checking bench for store_narrow_serializer: a table of directed
// stores, hand-written reset and back-pressure sequences, and randomized
// stores checked against a range-based reference model.
module tb_store_narrow_serializer;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  store_narrow_serializer_if #(.ADDR_WIDTH(32)) bus ();

  store_narrow_serializer #(.ADDR_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
    int          stall0;
    int          exp_n;
    logic [31:0] exp_bytes;
    bit          exp_trunc;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte count from the width, truncation from the signed range
  task automatic model(input logic [1:0] sel, input logic [31:0] data,
                       output int n, output bit tr);
    int sv;
    sv = int'($signed(data));
    case (sel)
      2'b01:   begin n = 2; tr = (sv < -32768) || (sv > 32767); end
      2'b11:   begin n = 1; tr = (sv < -128) || (sv > 127); end
      default: begin n = 4; tr = 1'b0; end
    endcase
  endtask

  // One store: issue it, follow every strobe, check bytes, latency and result
  task automatic do_store(input string name, input logic [1:0] sel, input logic [31:0] addr,
                          input logic [31:0] data, input int stall0, input bit rnd,
                          input int exp_n, input logic [31:0] exp_bytes, input bit exp_trunc);
    int  idx;
    int  stalls;
    int  st0;
    int  w;
    bit  fin;
    bit  mr;
    logic [31:0] exp_addr;
    @(negedge clock);
    w = 0;
    while (!bus.in_ready && w < 10) begin
      @(negedge clock);
      w++;
    end
    check({name, "_accept_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.select    = sel;
    bus.addr      = addr;
    bus.data      = data;
    bus.mem_ready = 1'b1;
    idx = 0; stalls = 0; st0 = stall0; fin = 1'b0;
    for (int cyc = 1; cyc <= 60 && !fin; cyc++) begin
      @(negedge clock);
      bus.in_valid = 1'b0;
      if (bus.done) begin
        check({name, "_nbytes"}, 32'(idx), 32'(exp_n));
        check({name, "_trunc"}, 32'(bus.trunc), 32'(exp_trunc));
        check({name, "_we_at_done"}, 32'(bus.mem_we), 32'd0);
        check({name, "_latency"}, 32'(cyc), 32'(exp_n + 1 + stalls));
        fin = 1'b1;
      end else if (bus.mem_we) begin
        if (idx < exp_n) begin
          exp_addr = addr + 32'(idx);
          check({name, "_addr"}, bus.mem_addr, exp_addr);
          check({name, "_wdata"}, 32'(bus.mem_wdata), 32'(8'(exp_bytes >> (8 * idx))));
        end else begin
          check({name, "_extra_strobe"}, 32'(bus.mem_we), 32'd0);
        end
        check({name, "_busy_ready"}, 32'(bus.in_ready), 32'd0);
        if (rnd) begin
          mr = ($urandom_range(0, 2) != 0);
        end else if (idx == 0 && st0 > 0) begin
          mr = 1'b0;
          st0--;
        end else begin
          mr = 1'b1;
        end
        bus.mem_ready = mr;
        if (mr) idx++;
        else stalls++;
      end else begin
        check({name, "_we_gap"}, 32'(bus.mem_we), 32'd1);
      end
    end
    check({name, "_timeout"}, 32'(fin), 32'd1);
    @(negedge clock);
    check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({name, "_trunc_clear"}, 32'(bus.trunc), 32'd0);
    check({name, "_ready_again"}, 32'(bus.in_ready), 32'd1);
    bus.mem_ready = 1'b1;
  endtask

  initial begin
    int          n;
    bit          tr;
    int          kind;
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;

    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{2'b11, 32'h0000_0100, 32'hFFFF_FF80, 0, 1, 32'h0000_0080, 1'b0};
    vecs[1] = '{2'b01, 32'h0000_0200, 32'h0000_1234, 3, 2, 32'h0000_1234, 1'b0};
    vecs[2] = '{2'b10, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 0, 4, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{2'b01, 32'h0000_0300, 32'h0001_8000, 0, 2, 32'h0000_8000, 1'b1};
    vecs[4] = '{2'b11, 32'h0000_0400, 32'h0000_007F, 0, 1, 32'h0000_007F, 1'b0};
    vecs[5] = '{2'b00, 32'h0000_0500, 32'h8000_0000, 1, 4, 32'h8000_0000, 1'b0};
    vecs[6] = '{2'b11, 32'h0000_0600, 32'h0000_0080, 0, 1, 32'h0000_0080, 1'b1};
    vecs[7] = '{2'b01, 32'h0000_0700, 32'hFFFF_8000, 0, 2, 32'h0000_8000, 1'b0};
    vecs[8] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FF7F, 2, 1, 32'h0000_007F, 1'b1};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.select    = 2'b00;
    bus.addr      = 32'd0;
    bus.data      = 32'd0;
    bus.mem_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_trunc", 32'(bus.trunc), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      do_store($sformatf("vec%0d", i), vecs[i].sel, vecs[i].addr, vecs[i].data,
               vecs[i].stall0, 1'b0, vecs[i].exp_n, vecs[i].exp_bytes, vecs[i].exp_trunc);
    end

    // Reset in the middle of a word store
    @(negedge clock);
    bus.in_valid = 1'b1; bus.select = 2'b10; bus.addr = 32'h0000_1000;
    bus.data = 32'h1122_3344; bus.mem_ready = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
    check("rst_mid_b0_addr", bus.mem_addr, 32'h0000_1000);
    check("rst_mid_b0_data", 32'(bus.mem_wdata), 32'h44);
    @(negedge clock);
    check("rst_mid_b1_data", 32'(bus.mem_wdata), 32'h33);
    reset = 1'b1;
    #1;
    check("rst_mid_we", 32'(bus.mem_we), 32'd0);
    check("rst_mid_ready", 32'(bus.in_ready), 32'd1);
    check("rst_mid_addr", bus.mem_addr, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      check("rst_after_done", 32'(bus.done), 32'd0);
      check("rst_after_we", 32'(bus.mem_we), 32'd0);
      check("rst_after_ready", 32'(bus.in_ready), 32'd1);
    end
    do_store("post_rst", 2'b11, 32'h0000_0A00, 32'h0000_0042, 0, 1'b0, 1, 32'h42, 1'b0);

    // Back-pressure: in_valid held across two requests
    @(negedge clock);
    check("bp_c0_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1; bus.select = 2'b01; bus.addr = 32'h0000_0800;
    bus.data = 32'h0000_ABCD; bus.mem_ready = 1'b1;
    @(negedge clock);
    check("bp_c1_we", 32'(bus.mem_we), 32'd1);
    check("bp_c1_addr", bus.mem_addr, 32'h0000_0800);
    check("bp_c1_data", 32'(bus.mem_wdata), 32'hCD);
    check("bp_c1_ready", 32'(bus.in_ready), 32'd0);
    bus.select = 2'b11; bus.addr = 32'h0000_0900; bus.data = 32'h0000_0005;
    @(negedge clock);
    check("bp_c2_addr", bus.mem_addr, 32'h0000_0801);
    check("bp_c2_data", 32'(bus.mem_wdata), 32'hAB);
    check("bp_c2_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clock);
    check("bp_c3_done", 32'(bus.done), 32'd1);
    check("bp_c3_trunc", 32'(bus.trunc), 32'd1);
    check("bp_c3_we", 32'(bus.mem_we), 32'd0);
    check("bp_c3_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clock);
    check("bp_c4_ready", 32'(bus.in_ready), 32'd1);
    check("bp_c4_we", 32'(bus.mem_we), 32'd0);
    check("bp_c4_done", 32'(bus.done), 32'd0);
    @(negedge clock);
    bus.in_valid = 1'b0;
    check("bp_c5_we", 32'(bus.mem_we), 32'd1);
    check("bp_c5_addr", bus.mem_addr, 32'h0000_0900);
    check("bp_c5_data", 32'(bus.mem_wdata), 32'h05);
    @(negedge clock);
    check("bp_c6_done", 32'(bus.done), 32'd1);
    check("bp_c6_trunc", 32'(bus.trunc), 32'd0);
    @(negedge clock);
    check("bp_c7_ready", 32'(bus.in_ready), 32'd1);

    // Randomized stores against the reference model
    for (int i = 0; i < 40; i++) begin
      sel  = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 1) == 1) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom;
      kind = int'($urandom_range(0, 2));
      if (kind == 0)      data = $urandom;
      else if (kind == 1) data = 32'(int'($urandom_range(0, 511)) - 256);
      else                data = 32'(int'($urandom_range(0, 131071)) - 65536);
      model(sel, data, n, tr);
      do_store($sformatf("rnd%0d", i), sel, addr, data, 0, 1'b1, n, data, tr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
